// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta converter family: control FSM encoding
// and the width of the saturating underrun counter.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sd_state_e;

  localparam int UCNT_W = 8;
  localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

endpackage

// File: rtl/sd_modulator1.sv
// First-order sigma-delta modulator: the accumulator carry-out is the
// pulse-density bit, registered one cycle after the addition.
module sd_modulator1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             carry
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, din};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst || clear) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (en) begin
      acc   <= sum[WIDTH-1:0];
      carry <= sum[WIDTH];
    end
  end

endmodule

// File: rtl/sigmadelta_dac.sv
// First-order sigma-delta DAC: one-entry sample buffer behind a valid/ready
// handshake, fixed sample period, IDLE/PRIME/RUN control and underrun tracking.
module sigmadelta_dac
  import sd_pkg::*;
#(
  parameter int DAC_WIDTH      = 8,
  parameter int PERIOD_BITS    = 10,
  parameter int INPUT_TOPOLOGY = 0
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DAC_WIDTH-1:0] digital_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 analog_out,
  output logic                 sample_tick,
  output logic                 underrun,
  output logic [UCNT_W-1:0]    underrun_cnt,
  output logic                 running
);

  sd_state_e              state, state_next;
  logic                   pend_full;
  logic [DAC_WIDTH-1:0]   pend_data;
  logic [DAC_WIDTH-1:0]   active;
  logic [PERIOD_BITS-1:0] period_cnt;
  logic                   run_go, wrap, load_now, write_now;

  assign run_go    = (state == RUN) && enable;
  assign wrap      = run_go && (period_cnt == '1);
  // The pending entry moves to active on entry to RUN and at every period wrap.
  assign load_now  = pend_full && enable && ((state == PRIME) || wrap);
  assign sample_ready = !pend_full || load_now;
  assign write_now = sample_valid && sample_ready;

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = PRIME;
      PRIME:   if (!enable) state_next = IDLE;
               else if (pend_full) state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= IDLE;
      pend_full    <= 1'b0;
      pend_data    <= '0;
      active       <= '0;
      period_cnt   <= '0;
      sample_tick  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      running      <= 1'b0;
    end else begin
      state       <= state_next;
      running     <= (state_next == RUN);
      sample_tick <= wrap;
      underrun    <= wrap && !pend_full;
      period_cnt  <= run_go ? period_cnt + 1'b1 : '0;

      if (wrap && !pend_full && (underrun_cnt != UCNT_MAX))
        underrun_cnt <= underrun_cnt + 1'b1;

      // The inverted-feedback topology is applied here, not at capture.
      if (load_now)
        active <= (INPUT_TOPOLOGY != 0) ? ~pend_data : pend_data;

      if (write_now) begin
        pend_full <= 1'b1;
        pend_data <= digital_in;
      end else if (load_now) begin
        pend_full <= 1'b0;
      end
    end
  end

  sd_modulator1 #(
    .WIDTH (DAC_WIDTH)
  ) u_mod (
    .clk_in (clk_in),
    .rst    (rst),
    .clear  (!run_go),
    .en     (run_go),
    .din    (active),
    .carry  (analog_out)
  );

endmodule

// File: tb/tb_sigmadelta_dac.sv
// Bench for sigmadelta_dac: direct and inverted-topology instances share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_sigmadelta_dac;

  localparam int W      = 8;
  localparam int PB     = 10;
  localparam int PERIOD = 1 << PB;
  localparam int FULL   = 1 << W;

  logic         clk_in = 1'b0;
  logic         rst, enable, sample_valid;
  logic [W-1:0] digital_in;
  logic         sample_ready [2];
  logic         analog_out   [2];
  logic         sample_tick  [2];
  logic         underrun     [2];
  logic [7:0]   underrun_cnt [2];
  logic         running      [2];

  always #5 clk_in = ~clk_in;

  sigmadelta_dac #(.DAC_WIDTH(W), .PERIOD_BITS(PB), .INPUT_TOPOLOGY(0)) dut0 (
    .clk_in(clk_in), .rst(rst), .enable(enable), .digital_in(digital_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready[0]),
    .analog_out(analog_out[0]), .sample_tick(sample_tick[0]),
    .underrun(underrun[0]), .underrun_cnt(underrun_cnt[0]), .running(running[0]));

  sigmadelta_dac #(.DAC_WIDTH(W), .PERIOD_BITS(PB), .INPUT_TOPOLOGY(1)) dut1 (
    .clk_in(clk_in), .rst(rst), .enable(enable), .digital_in(digital_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready[1]),
    .analog_out(analog_out[1]), .sample_tick(sample_tick[1]),
    .underrun(underrun[1]), .underrun_cnt(underrun_cnt[1]), .running(running[1]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 waiting for first sample, 2 running.
  int m_mode  [2];
  int m_q     [2][$];
  int m_active[2];
  int m_acc   [2];
  int m_phase [2];
  int m_ucnt  [2];
  bit m_out   [2];
  bit m_tick  [2];
  bit m_under [2];
  bit m_run   [2];

  task automatic model_reset(input int i);
    m_mode[i] = 0;  m_q[i].delete();
    m_active[i] = 0; m_acc[i] = 0; m_phase[i] = 0; m_ucnt[i] = 0;
    m_out[i] = 0; m_tick[i] = 0; m_under[i] = 0; m_run[i] = 0;
  endtask

  function automatic bit m_loads(input int i);
    return enable && (m_q[i].size() != 0) &&
           (m_mode[i] == 1 || (m_mode[i] == 2 && m_phase[i] == PERIOD - 1));
  endfunction

  function automatic logic [12:0] m_vec(input int i);
    bit rdy;
    rdy = (m_q[i].size() == 0) || m_loads(i);
    return {m_out[i], rdy, m_tick[i], m_under[i], 8'(m_ucnt[i]), m_run[i]};
  endfunction

  task automatic model_step(input int i);
    bit boundary, load, rdy;
    int sum, v, nxt;
    if (rst) begin
      model_reset(i);
    end else begin
      boundary = (m_mode[i] == 2) && enable && (m_phase[i] == PERIOD - 1);
      load     = m_loads(i);
      rdy      = (m_q[i].size() == 0) || load;
      m_tick[i]  = boundary;
      m_under[i] = boundary && (m_q[i].size() == 0);
      if (m_under[i] && m_ucnt[i] < 255) m_ucnt[i]++;
      if (m_mode[i] == 2 && enable) begin
        sum = m_acc[i] + m_active[i];
        m_out[i]   = (sum >= FULL);
        m_acc[i]   = sum % FULL;
        m_phase[i] = (m_phase[i] + 1) % PERIOD;
      end else begin
        m_out[i] = 0; m_acc[i] = 0; m_phase[i] = 0;
      end
      if (load) begin
        v = m_q[i].pop_front();
        m_active[i] = (i == 1) ? (FULL - 1 - v) : v;
      end
      if (sample_valid && rdy) m_q[i].push_back(int'(digital_in));
      if (!enable)                  nxt = 0;
      else if (m_mode[i] == 0)      nxt = 1;
      else if (m_mode[i] == 1 && load) nxt = 2;
      else                          nxt = m_mode[i];
      m_mode[i] = nxt;
      m_run[i]  = (nxt == 2);
    end
  endtask

  bit         d_rst, d_en, d_valid;
  logic [7:0] d_data;
  bit         obs_out[2], obs_ready[2], obs_run[2];
  logic [7:0] obs_ucnt[2];
  int         tick_total[2] = '{0, 0};
  int         under_total[2] = '{0, 0};
  bit         started = 0;
  int         k = 0;
  int         last_tick_k = -1;

  // One clock: observe and compare at the falling edge, then drive the next inputs.
  task automatic cycle();
    @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("outs%0d", i),
            {analog_out[i], sample_ready[i], sample_tick[i], underrun[i],
             underrun_cnt[i], running[i]}, m_vec(i));
      obs_out[i] = analog_out[i]; obs_ready[i] = sample_ready[i];
      obs_run[i] = running[i];    obs_ucnt[i]  = underrun_cnt[i];
      if (sample_tick[i]) tick_total[i]++;
      if (underrun[i])    under_total[i]++;
    end
    if (started) begin
      k++;
      if (sample_tick[0]) begin
        if (last_tick_k >= 0) check("tick_gap", k - last_tick_k, PERIOD);
        last_tick_k = k;
      end
    end
    rst = d_rst; enable = d_en; sample_valid = d_valid; digital_in = d_data;
    for (int i = 0; i < 2; i++) model_step(i);
  endtask

  task automatic step_to(input int target);
    while (k < target) cycle();
  endtask

  task automatic push_at(input int at, input logic [7:0] data);
    step_to(at - 1);
    d_valid = 1; d_data = data;
    cycle();
    d_valid = 0;
  endtask

  task automatic count_ones(input int first, input int last, output int c0, output int c1);
    step_to(first - 1);
    c0 = 0; c1 = 0;
    for (int j = first; j <= last; j++) begin
      cycle();
      c0 += int'(obs_out[0]);
      c1 += int'(obs_out[1]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1;
    rst = 1; enable = 0; sample_valid = 0; digital_in = '0;
    d_rst = 1; d_en = 0; d_valid = 0; d_data = '0;
    for (int i = 0; i < 2; i++) model_reset(i);

    repeat (3) cycle();
    d_rst = 0; d_en = 1;
    cycle();
    check("rst_out",     obs_out[0],   0);
    check("rst_ready",   obs_ready[0], 1);
    check("rst_running", obs_run[0],   0);
    check("rst_ucnt",    obs_ucnt[0],  0);

    repeat (20) cycle();
    check("prime_running", obs_run[0],   0);
    check("prime_ready",   obs_ready[0], 1);
    check("prime_ucnt",    obs_ucnt[0],  0);

    d_valid = 1; d_data = 8'h80;
    cycle();
    d_valid = 0;
    for (int w = 0; w < 10 && !started; w++) begin
      cycle();
      if (obs_run[0]) begin started = 1; k = 0; end
    end
    if (!started) begin
      check("run_start", obs_run[0], 1);
      started = 1; k = 0;
    end

    for (int j = 1; j <= 4; j++) begin
      cycle();
      check("pattern_80", obs_out[0], (j % 2 == 0));
    end
    count_ones(5, 260, c0, c1);
    check("ones_80", c0, 128);
    check("ones_80_inv", c1, 127);

    push_at(300, 8'hFF);
    count_ones(1025, 1280, c0, c1);
    check("ones_ff", c0, 255);
    check("ones_ff_inv", c1, 0);

    push_at(1300, 8'h00);
    count_ones(2049, 3072, c0, c1);
    check("ones_00", c0, 0);
    check("ones_00_inv", c1, 1020);

    count_ones(3073, 4096, c0, c1);
    check("held_00", c0, 0);
    check("held_00_inv", c1, 1020);
    step_to(4100);
    check("ucnt_two",     obs_ucnt[0],    2);
    check("underrun_cnt", under_total[0], 2);
    check("tick_count",   tick_total[0],  4);

    push_at(4101, 8'h10);
    step_to(5109);
    d_valid = 1; d_data = 8'h20;
    step_to(5118);
    check("ready_full", obs_ready[0], 0);
    cycle();
    check("ready_wrap", obs_ready[0], 1);
    d_valid = 0;
    count_ones(5121, 5376, c0, c1);
    check("ones_10", c0, 16);
    check("ones_10_inv", c1, 239);

    step_to(6129);
    d_valid = 1; d_data = 8'h30;
    step_to(6142);
    check("ready_full2", obs_ready[0], 0);
    cycle();
    check("ready_wrap2", obs_ready[0], 1);
    d_valid = 0;
    count_ones(6145, 6400, c0, c1);
    check("ones_20", c0, 32);
    check("ones_20_inv", c1, 223);
    count_ones(7169, 7424, c0, c1);
    check("ones_30", c0, 48);
    check("ones_30_inv", c1, 207);
    step_to(8193);
    check("ucnt_three", obs_ucnt[1], 3);

    push_at(8194, 8'h55);
    step_to(8300);
    d_rst = 1;
    cycle();
    d_rst = 0;
    cycle();
    check("midrst_out",   obs_out[0],   0);
    check("midrst_run",   obs_run[0],   0);
    check("midrst_ready", obs_ready[0], 1);
    check("midrst_ucnt",  obs_ucnt[0],  0);
    repeat (10) cycle();
    check("midrst_pending_dropped", obs_run[0], 0);
    started = 0;

    for (int n = 0; n < 8000; n++) begin
      d_rst = ($urandom_range(0, 2047) == 0);
      if (d_en) begin
        if ($urandom_range(0, 999) == 0) d_en = 0;
      end else if ($urandom_range(0, 19) == 0) begin
        d_en = 1;
      end
      d_valid = ($urandom_range(0, 31) == 0);
      d_data  = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sigmadelta_dac.md
Name: sigmadelta_dac

Overview:
- First-order sigma-delta DAC. It is the transmit-side counterpart of the sigma-delta ADC front end.
- Accepts parallel samples over a valid/ready handshake and holds each sample for a fixed sample period.
- Produces a 1-bit pulse-density stream on analog_out, which drives an external RC low-pass filter to form the analog voltage.
- Includes a one-entry input buffer, a sample-period counter, a 3-state control FSM and underrun detection.

Parameters:
- DAC_WIDTH, 8, sample width in bits; output density = digital_in / 2^DAC_WIDTH.
- PERIOD_BITS, 10, sample period = 2^PERIOD_BITS clk_in cycles per sample.
- INPUT_TOPOLOGY, 0, 0 = direct; 1 = inverted feedback network, where the sample is bit-inverted before modulation.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run request; low forces IDLE.
- digital_in  input  DAC_WIDTH  sample data.
- sample_valid  input  1  digital_in is valid.
- sample_ready  output  1  buffer can accept a sample this cycle.
- analog_out  output  1  registered PDM bitstream to the RC filter.
- sample_tick  output  1  one-cycle pulse at each sample-period boundary.
- underrun  output  1  one-cycle pulse when a boundary finds the buffer empty.
- underrun_cnt  output  8  saturating count of underruns since reset.
- running  output  1  high in the RUN state.

Behaviour:
- Reset (rst=1 at a clk_in edge) clears everything: pending buffer empty, active sample 0, accumulator 0, period counter 0, state IDLE.
- Reset output values: analog_out=0, sample_ready=1, sample_tick=0, underrun=0, underrun_cnt=0, running=0.
- Reset takes effect mid-operation the same way; a pending sample is discarded.
- Handshake:
  - A transfer occurs when sample_valid & sample_ready are high on the same edge.
  - sample_ready = !pending_full | load_now, where load_now means the pending entry moves to active on this edge. A new write and a load in the same cycle are therefore legal.
  - digital_in is captured unmodified; the INPUT_TOPOLOGY inversion is applied at load to active.
- FSM states:
  - IDLE: period counter held at 0, accumulator cleared, analog_out=0. The buffer still accepts one sample. Move to PRIME when enable=1.
  - PRIME: analog_out=0, counter held at 0. When pending_full, load active, clear pending, move to RUN. The counter starts at 0 on the first RUN cycle.
  - RUN: the counter increments every cycle and wraps from 2^PERIOD_BITS-1 to 0. On the wrap edge, sample_tick=1.
    - If pending_full: load active and clear pending.
    - Otherwise: keep the old active sample, pulse underrun, and increment underrun_cnt (saturates at 255).
  - From PRIME or RUN, enable=0 goes to IDLE on the next edge. The accumulator and analog_out clear on that edge; pending is kept.
- Modulator (RUN only, every cycle):
  - sum = {1'b0,acc} + {1'b0,active}, DAC_WIDTH+1 bits.
  - acc <= sum[DAC_WIDTH-1:0]; analog_out <= sum[DAC_WIDTH].
  - Latency: one cycle from acc/active to analog_out.
  - A new active sample affects the sum on the cycle after the load edge.
  - The accumulator is not cleared at sample boundaries, so no phase reset occurs.
- Arithmetic limits:
  - active=0 gives a constant 0.
  - active=2^DAC_WIDTH-1 gives ones density (2^N-1)/2^N; full-scale 1 is unreachable, by design.
- Outputs sample_tick, underrun and running are registered.

Decomposition:
- Shared package sd_pkg: FSM state encoding (IDLE=2'd0, PRIME=2'd1, RUN=2'd2) and the underrun counter width constant UCNT_W=8. The ADC side reuses the DAC_WIDTH/ADC_WIDTH conventions.
- One natural sub-module: sd_modulator1 (accumulator, carry output, clear/enable inputs). The handshake, period counter and FSM stay in sigmadelta_dac.

Test Plan:
- Hold rst=1 for 3 cycles, then enable=1 with no valid -> state PRIME, analog_out=0, sample_ready=1, underrun_cnt=0 indefinitely.
- DAC_WIDTH=8, push 0x80, enable -> analog_out pattern 0,1,0,1 starting on the second RUN cycle. The ones count over 256 cycles = 128.
- Push 0xFF, then 0x00, feeding the next sample before each tick -> 255 ones in the first 256-cycle window of the 0xFF period, then all zeros after the boundary.
- Push one sample only, run for 3 periods -> underrun pulses at boundaries 1 and 2, underrun_cnt=2, the old sample is held, and sample_tick pulses every 1024 cycles.
- Buffer full with sample_valid held on the wrap cycle -> sample_ready=1 on that cycle. The old pending loads to active and the new sample lands in pending, with no loss or duplication (check by sequence 0x10, 0x20, 0x30).
- INPUT_TOPOLOGY=1, push 0x00 -> density 255/256. Also assert rst mid-period -> next-cycle analog_out=0, running=0, pending empty.
